// File: rtl/tdm_tx_multi.sv
// rtl/tdm_tx_multi.sv - parametrised TDM serial transmitter with double-buffered slot samples
module tdm_tx_multi #(
  parameter int                   SLOTS     = 8,
  parameter int                   SLOT_BITS = 32,
  parameter int                   DATA_BITS = 24,
  parameter int                   DELAY     = 1,
  parameter logic [DATA_BITS-1:0] PATTERN   = 24'hABCD00,
  parameter int                   SW        = $clog2(SLOTS)
) (
  input  logic                 bclk,
  input  logic                 rst_n,
  input  logic                 wclk,
  input  logic                 wr_en,
  input  logic [SW-1:0]        wr_slot,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 pat_en,
  input  logic                 err_clr,
  output logic                 tdm_out,
  output logic                 frame_start,
  output logic [SW-1:0]        slot_idx,
  output logic                 sync_err
);

  localparam int FRAME_BITS = SLOTS * SLOT_BITS;
  localparam int IDLE_CNT   = FRAME_BITS + DELAY;
  localparam int CW         = $clog2(IDLE_CNT + 1);
  localparam int DW         = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic [1:0]           wc_ff;
  logic                 pat_en_q;
  logic                 err_clr_q;
  logic [DATA_BITS-1:0] shadow [SLOTS];
  logic                 sync_det;

  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      wc_ff     <= 2'b00;
      pat_en_q  <= 1'b0;
      err_clr_q <= 1'b0;
      for (int i = 0; i < SLOTS; i++) shadow[i] <= '0;
    end else begin
      wc_ff     <= {wc_ff[0], wclk};
      pat_en_q  <= pat_en;
      err_clr_q <= err_clr;
      if (wr_en && (int'(wr_slot) < SLOTS)) shadow[wr_slot] <= wr_data;
    end
  end

  assign sync_det = (wc_ff == 2'b01);

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nx;
  logic [DATA_BITS-1:0] active [SLOTS];
  logic                 pat_lat;
  logic                 dly_bit;
  logic                 err_set;
  logic                 u_nx;
  logic [SW-1:0]        u_slot;
  logic [DATA_BITS-1:0] word;
  logic                 o_valid;
  logic [SW-1:0]        o_slot;
  int                   u_bit;
  int                   o_bit;

  // u_nx is the undelayed bit for the new cnt; the DELAY stage below shifts it onto the pin,
  // which is what carries the previous frame's tail into the cnt<DELAY positions.
  always_comb begin
    cnt_nx = cnt;
    if (sync_det)                  cnt_nx = '0;
    else if (cnt != CW'(IDLE_CNT)) cnt_nx = cnt + CW'(1);
    err_set = sync_det && (cnt < CW'(FRAME_BITS - 1));

    u_slot = SW'(int'(cnt_nx) / SLOT_BITS);
    u_bit  = int'(cnt_nx) % SLOT_BITS;
    word   = sync_det ? shadow[u_slot] : active[u_slot];
    if (sync_det ? pat_en_q : pat_lat) word = PATTERN ^ DATA_BITS'(u_slot);
    u_nx = 1'b0;
    if ((int'(cnt_nx) < FRAME_BITS) && (u_bit < DATA_BITS))
      u_nx = word[DW'(DATA_BITS - 1 - u_bit)];

    o_bit   = int'(cnt_nx) - DELAY;
    o_valid = (int'(cnt_nx) >= DELAY) && (int'(cnt_nx) < IDLE_CNT);
    o_slot  = o_valid ? SW'(o_bit / SLOT_BITS) : SW'(SLOTS - 1);
  end

  always_ff @(negedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= CW'(IDLE_CNT);
      pat_lat     <= 1'b0;
      dly_bit     <= 1'b0;
      tdm_out     <= 1'b0;
      frame_start <= 1'b0;
      slot_idx    <= SW'(SLOTS - 1);
      sync_err    <= 1'b0;
      for (int i = 0; i < SLOTS; i++) active[i] <= '0;
    end else begin
      cnt <= cnt_nx;
      if (sync_det) begin
        pat_lat <= pat_en_q;
        for (int i = 0; i < SLOTS; i++) active[i] <= shadow[i];
      end
      dly_bit     <= u_nx;
      tdm_out     <= (DELAY == 0) ? u_nx : dly_bit;
      frame_start <= o_valid && (o_bit == 0);
      slot_idx    <= o_slot;
      if (err_set)        sync_err <= 1'b1;
      else if (err_clr_q) sync_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdm_tx_multi.sv
// tb/tb_tdm_tx_multi.sv - self-checking bench for tdm_tx_multi against a frame-level model
module tb_tdm_tx_multi;

  localparam int          SLOT_BITS  = 32;
  localparam int          DATA_BITS  = 24;
  localparam int          FRAME_BITS = 256;
  localparam logic [23:0] PAT        = 24'hABCD00;

  logic        bclk = 1'b0, rst_n = 1'b0, wclk = 1'b0, wr_en = 1'b0;
  logic        pat_en = 1'b0, err_clr = 1'b0;
  logic [2:0]  wr_slot = '0;
  logic [23:0] wr_data = '0;
  logic        tdm_out, frame_start, sync_err;
  logic [2:0]  slot_idx;

  tdm_tx_multi #(
    .SLOTS(8), .SLOT_BITS(32), .DATA_BITS(24), .DELAY(1), .PATTERN(24'hABCD00)
  ) dut (
    .bclk(bclk), .rst_n(rst_n), .wclk(wclk), .wr_en(wr_en), .wr_slot(wr_slot),
    .wr_data(wr_data), .pat_en(pat_en), .err_clr(err_clr), .tdm_out(tdm_out),
    .frame_start(frame_start), .slot_idx(slot_idx), .sync_err(sync_err)
  );

  always #5 bclk = ~bclk;

  int checks = 0;
  int errors = 0;

  logic [23:0]  m_shadow [8];
  logic [255:0] m_frame;
  logic [255:0] obs;
  logic         m_prev_w, m_sync, m_pat_s, m_clr_s, m_err, m_carry;
  int           m_k;
  int           fs_k;
  logic [23:0]  old2;
  int           per;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic fbit(input int b);
    logic [255:0] t;
    t = m_frame << b;
    return t[255];
  endfunction

  function automatic logic [31:0] slot_word(input int s);
    logic [255:0] t;
    t = obs << (32 * s);
    return t[255:224];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_shadow[i] = '0;
    m_frame = '0; m_prev_w = 0; m_sync = 0; m_pat_s = 0; m_clr_s = 0;
    m_err = 0; m_carry = 0; m_k = FRAME_BITS + 1;
  endtask

  // Frame content: slot 0 in the top 32 bits, each slot = word then zero padding.
  task automatic build_frame();
    logic [23:0] w;
    m_frame = '0;
    for (int s = 0; s < 8; s++) begin
      w = m_pat_s ? (PAT ^ 24'(s)) : m_shadow[3'(s)];
      m_frame = {m_frame[223:0], w, 8'h00};
    end
  endtask

  task automatic cycle();
    logic e_tdm, e_fs;
    logic [2:0] e_slot;
    int b;
    @(posedge bclk);
    if (!rst_n) model_reset();
    else begin
      m_sync   = !m_prev_w && wclk;
      m_prev_w = wclk;
      m_pat_s  = pat_en;
      m_clr_s  = err_clr;
      if (wr_en) m_shadow[wr_slot] = wr_data;
    end
    @(negedge bclk);
    e_tdm = 0; e_fs = 0; e_slot = 3'd7;
    if (!rst_n) model_reset();
    else begin
      if (m_sync && (m_k < FRAME_BITS - 1)) m_err = 1;
      else if (m_clr_s)                     m_err = 0;
      if (m_sync) begin
        m_carry = (m_k < FRAME_BITS) ? fbit(m_k) : 1'b0;
        build_frame();
        m_k = 0;
      end else if (m_k < FRAME_BITS + 1) m_k++;
      if (m_k == 0) e_tdm = m_carry;
      else if (m_k - 1 < FRAME_BITS) begin
        b = m_k - 1;
        e_tdm = fbit(b); e_fs = (b == 0); e_slot = 3'(b / SLOT_BITS);
      end
    end
    #1;
    chk("tdm_out", 32'(tdm_out), 32'(e_tdm));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("slot_idx", 32'(slot_idx), 32'(e_slot));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    if (rst_n && m_k >= 1 && m_k - 1 < FRAME_BITS) begin
      b = m_k - 1;
      if (b == 0) obs = '0;
      if (tdm_out === 1'b1) obs = obs | (256'(1) << (255 - b));
    end
    if (frame_start === 1'b1) fs_k = m_k;
  endtask

  task automatic frame(input int period, input int high, input int wr_at = -1,
                       input logic [2:0] ws = 0, input logic [23:0] wd = 0,
                       input int pat_at = -1, input logic pv = 0, input int clr_at = -1);
    for (int c = 0; c < period; c++) begin
      wclk    = (c < high);
      wr_en   = (c == wr_at);
      wr_slot = ws;
      wr_data = wd;
      if (c == pat_at) pat_en = pv;
      err_clr = (c == clr_at);
      cycle();
    end
    wr_en = 0; err_clr = 0;
  endtask

  task automatic wr(input logic [2:0] s, input logic [23:0] d);
    wclk = 0; wr_en = 1; wr_slot = s; wr_data = d;
    cycle();
    wr_en = 0;
  endtask

  initial begin
    model_reset();
    obs = '0; fs_k = -1;
    repeat (3) cycle();
    rst_n = 1;

    // idle data: two frames of zeros
    frame(256, 128);
    frame(256, 128);
    chk("idle_frame_zero", 32'(obs != '0), 32'd0);

    // randomized writes and frame lengths
    for (int f = 0; f < 3; f++) begin
      per = $urandom_range(256, 270);
      for (int c = 0; c < per; c++) begin
        wclk    = (c < 128);
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_slot = 3'($urandom);
        wr_data = 24'($urandom);
        cycle();
      end
    end
    wr_en = 0;

    // data layout
    wr(3'd0, 24'h800001);
    wr(3'd1, 24'hFFFFFF);
    fs_k = -1;
    frame(256, 128);
    chk("slot0_word", slot_word(0), 32'h80000100);
    chk("slot1_word", slot_word(1), 32'hFFFFFF00);
    chk("fs_at_cnt1", 32'(fs_k), 32'd1);

    // test pattern, pat_en dropped mid-frame
    pat_en = 1;
    frame(256, 128, -1, 0, 0, 100, 1'b0);
    chk("pat_slot5", slot_word(5), 32'hABCD0500);
    chk("pat_slot0", slot_word(0), 32'hABCD0000);
    frame(256, 128);
    chk("pat_off_slot0", slot_word(0), 32'h80000100);

    // double buffer
    old2 = 24'($urandom);
    wr(3'd2, old2);
    frame(256, 128, 40, 3'd2, 24'h123456);
    chk("dbuf_old", slot_word(2), {old2, 8'h00});
    frame(256, 128);
    chk("dbuf_new", slot_word(2), 32'h12345600);

    // early sync at cnt 100, then clear
    frame(101, 50);
    wclk = 1; cycle();
    chk("early_err_set", 32'(sync_err), 32'd1);
    wclk = 1; cycle();
    chk("resync_fs", 32'(frame_start), 32'd1);
    for (int c = 2; c < 256; c++) begin
      wclk = (c < 128);
      cycle();
    end
    chk("err_sticky", 32'(sync_err), 32'd1);
    frame(256, 128, -1, 0, 0, -1, 0, 10);
    chk("err_cleared", 32'(sync_err), 32'd0);

    // long frames
    frame(300, 150);
    frame(300, 150);
    chk("long_err", 32'(sync_err), 32'd0);
    chk("long_slot", 32'(slot_idx), 32'd7);
    chk("long_tdm", 32'(tdm_out), 32'd0);

    // asynchronous reset mid-frame
    frame(101, 50);
    wclk = 1; cycle();
    repeat (40) begin
      wclk = 1; cycle();
    end
    chk("pre_rst_tdm", 32'(tdm_out), 32'd1);
    chk("pre_rst_err", 32'(sync_err), 32'd1);
    rst_n = 0;
    #1;
    chk("rst_tdm", 32'(tdm_out), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_slot", 32'(slot_idx), 32'd7);
    chk("rst_err", 32'(sync_err), 32'd0);
    wclk = 0;
    repeat (2) cycle();
    rst_n = 1;
    frame(256, 128);
    frame(256, 128);
    chk("post_rst_zero", 32'(obs != '0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_tx_multi.md
Name: tdm_tx_multi

Overview:
- Parametrised TDM serial transmitter; successor to the fixed-pattern TDM test generator.
- Serialises SLOTS channels of DATA_BITS samples into SLOT_BITS-wide slots, MSB first, framed by an externally supplied word clock.
- Double-buffered sample registers are written from the bclk domain; a built-in test-pattern mode replaces the data.
- Reports frame-sync errors.
- Sits between the audio datapath and the TDM output pin.

Parameters:
- SLOTS, 8, slots per frame (2..16).
- SLOT_BITS, 32, bits per slot (8..32).
- DATA_BITS, 24, sample width; must be <= SLOT_BITS; left-justified in the slot, zero-padded.
- DELAY, 1, bit delay from frame sync to slot-0 MSB; 0 or 1 (1 = I2S style).
- PATTERN, 24'hABCD00, DATA_BITS-wide test word.
- SW, $clog2(SLOTS), slot index width.

Ports:
- bclk  in  1  bit clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- wclk  in  1  frame sync; rising edge marks frame start.
- wr_en  in  1  write strobe, sampled on rising bclk.
- wr_slot  in  SW  slot address for the write.
- wr_data  in  DATA_BITS  sample to write.
- pat_en  in  1  test-pattern mode select.
- err_clr  in  1  clears sync_err.
- tdm_out  out  1  serial data.
- frame_start  out  1  one-bclk pulse with the slot-0 MSB.
- slot_idx  out  SW  slot currently driven on tdm_out.
- sync_err  out  1  sticky early-sync flag.

Behaviour:
- Clock edges: wclk sync, writes, pat_en and err_clr are sampled on rising bclk. tdm_out, frame_start, slot_idx and all sequencer state update on falling bclk.
- Reset (async, rst_n=0):
  - Outputs: tdm_out=0, frame_start=0, slot_idx=SLOTS-1, sync_err=0.
  - State: wc_ff=2'b00, both banks all-zero, cnt=FRAME_BITS+DELAY (idle).
  - Effect is immediate mid-frame; release begins idle.
- Definitions:
  - FRAME_BITS = SLOTS*SLOT_BITS.
  - wc_ff is a 2-stage shift of wclk on rising bclk.
  - sync_det = (wc_ff == 2'b01).
- Sync handling: on the falling edge after a rising edge where sync_det=1:
  - cnt<=0.
  - Shadow bank copies into active bank; pat_en is latched.
  - Otherwise cnt increments, saturating at FRAME_BITS+DELAY.
- Bit mapping:
  - Frame bit b = cnt-DELAY; slot s = b/SLOT_BITS; j = b%SLOT_BITS.
  - tdm_out = word_s[DATA_BITS-1-j] if j<DATA_BITS, else 0.
  - word_s = active[s], or PATTERN ^ s (s in low SW bits) when latched pat_en=1.
  - Bits at cnt<DELAY: carry the previous frame's last DELAY bits (zero padding when DATA_BITS<SLOT_BITS; 0 after reset or idle).
  - b>=FRAME_BITS: tdm_out=0 (idle).
- slot_idx: equals s while 0<=b<FRAME_BITS; otherwise SLOTS-1.
- frame_start: 1 exactly when b==0.
- Writes: wr_en=1 stores wr_data into shadow[wr_slot] on rising bclk.
  - A write on the rising edge that also raises sync_det is included in the new frame.
  - Writes never alter the frame in progress.
  - wr_slot>=SLOTS is ignored.
- Sync error:
  - Expected sync_det is at cnt==FRAME_BITS-1, or later while idle (long frames are legal).
  - sync_det at cnt<FRAME_BITS-1 sets sync_err and still restarts the frame (resync).
  - err_clr=1 clears sync_err on falling bclk unless a new error occurs in the same cycle; set wins.
- pat_en changes take effect only at the next frame start.

Test Plan:
- Reset/idle: assert rst_n=0 mid-frame -> tdm_out=0, slot_idx=7, sync_err=0 immediately. Release, wclk every 256 bclk, no writes -> tdm_out stays 0.
- Data layout (DELAY=1): write shadow[0]=24'h800001, shadow[1]=24'hFFFFFF, then sync.
  - frame_start=1 at cnt 1.
  - Slot 0 stream: 1, 22 zeros, 1, then 8 zeros.
  - Slot 1 stream: 24 ones, then 8 zeros.
  - slot_idx steps 0..7 every 32 bclk.
- Pattern: pat_en=1 before sync -> slot 5 serialises 24'hABCD05 and slot 0 serialises 24'hABCD00. Toggling pat_en mid-frame has no effect until the next frame.
- Early sync: second wclk rise placed so sync_det hits cnt=100 -> sync_err=1, frame restarts with frame_start at cnt 1. err_clr pulse -> sync_err=0.
- Long frame: wclk period 300 bclk -> bits after the 256th are 0 with slot_idx=7, sync_err stays 0.
- Double buffer: write shadow[2]=24'h123456 during slot 1 of frame N -> slot 2 of frame N carries the old value; frame N+1 carries 24'h123456.
